// File: rtl/onehot_encoder_seq_pkg.sv
// Shared definitions for the sequential one-hot/multi-hot to index encoder.
// Holds the scan FSM state type, the default index and vector widths, and
// the group geometry of the two-level priority tree.
package onehot_encoder_seq_pkg;

    localparam int IN   = 10;          // index width
    localparam int OUT  = 1 << IN;     // vector width (2**IN)
    localparam int G    = 32;          // bits per priority group
    localparam int NGRP = OUT / G;     // number of groups
    localparam int GW   = $clog2(G);   // in-group index width

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_encoder_seq_if.sv
// Stream bundle between a vector producer and an index consumer.
//   vec/vec_valid/vec_ready : input vector stream
//   idx/idx_valid/idx_ready : output index stream, idx_last marks the final
//                             set bit of a vector
//   none                    : one-cycle pulse after an all-zero vector
// master = producer/consumer side, slave = encoder side.
interface onehot_encoder_seq_if;
    import onehot_encoder_seq_pkg::*;

    logic [OUT-1:0] vec;
    logic           vec_valid;
    logic           vec_ready;
    logic [IN-1:0]  idx;
    logic           idx_valid;
    logic           idx_ready;
    logic           idx_last;
    logic           none;

    modport master (
        output vec, vec_valid, idx_ready,
        input  vec_ready, idx, idx_valid, idx_last, none
    );

    modport slave (
        input  vec, vec_valid, idx_ready,
        output vec_ready, idx, idx_valid, idx_last, none
    );

endinterface

// File: rtl/onehot_encoder_seq_prio_enc32.sv
// 32-bit lowest-first priority encoder.
//   din : input bits
//   idx : index of the lowest set bit (0 when din is zero)
//   any : din has at least one bit set
module prio_enc32 (
    input  logic [31:0] din,
    output logic [4:0]  idx,
    output logic        any
);

    always_comb begin
        idx = '0;
        // Walk downwards so the lowest set bit is the last one to win.
        for (int i = 31; i >= 0; i--) begin
            if (din[i]) begin
                idx = 5'(i);
            end
        end
        any = |din;
    end

endmodule

// File: rtl/onehot_encoder_seq.sv
// Sequential encoder: accepts a 1024-bit vector and emits the index of each
// set bit, lowest first, one per cycle.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : stream bundle (slave side), see onehot_encoder_seq_if
// Outputs are decoded from the registered remainder and state only.
module onehot_encoder_seq
    import onehot_encoder_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    onehot_encoder_seq_if.slave  bus
);

    state_t         state_reg, state_next;
    logic [OUT-1:0] rem_reg, rem_next;
    logic           none_reg, none_next;

    logic [GW-1:0]   grp_idx [NGRP];
    logic [NGRP-1:0] grp_any;
    logic [NGRP-1:0] grp_multi;     // group holds more than one set bit
    logic [OUT-1:0]  rem_clr;       // rem with its lowest set bit cleared
    logic [GW-1:0]   sel_grp;
    logic            any_set;
    logic            single_grp;
    logic            idx_last_int;

    // First level: one encoder per group, plus the per-group "lowest bit
    // cleared" value. Only the selected group actually loses a bit.
    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
            logic [G-1:0] grp_bits;
            assign grp_bits = rem_reg[gi*G +: G];

            prio_enc32 u_pe (
                .din (grp_bits),
                .idx (grp_idx[gi]),
                .any (grp_any[gi])
            );

            assign grp_multi[gi]      = |(grp_bits & (grp_bits - G'(1)));
            assign rem_clr[gi*G +: G] = (sel_grp == GW'(gi))
                                      ? (grp_bits & (grp_bits - G'(1)))
                                      : grp_bits;
        end
    endgenerate

    // Second level: pick the lowest non-empty group.
    prio_enc32 u_grp_sel (
        .din (grp_any),
        .idx (sel_grp),
        .any (any_set)
    );

    // Exactly one bit remains when exactly one group is non-empty and that
    // group itself holds a single bit.
    assign single_grp   = ~|(grp_any & (grp_any - NGRP'(1)));
    assign idx_last_int = (state_reg == SCAN) && any_set && single_grp
                        && !grp_multi[sel_grp];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            none_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            none_reg  <= none_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        none_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.vec_valid) begin
                    rem_next = bus.vec;
                    if (|bus.vec) begin
                        state_next = SCAN;
                    end else begin
                        none_next = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.idx_ready) begin
                    rem_next = rem_clr;
                    if (idx_last_int) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        bus.vec_ready = (state_reg == IDLE);
        bus.idx_valid = (state_reg == SCAN);
        bus.idx       = {sel_grp, grp_idx[sel_grp]};
        bus.idx_last  = idx_last_int;
        bus.none      = none_reg;
    end

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Directed bench for onehot_encoder_seq. A queue model holds the indices
// still owed for the current vector; a per-cycle compare process checks the
// DUT against it, and directed steps pin literal expectations.
module tb_onehot_encoder_seq;
    import onehot_encoder_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    onehot_encoder_seq_if bus ();

    onehot_encoder_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int exp_q[$];       // indices still to be emitted, lowest first
    bit none_exp = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: idle means nothing left to emit.
    always @(posedge clk) begin
        bit idle;
        idle = (exp_q.size() == 0);
        if (rst) begin
            exp_q.delete();
            none_exp = 1'b0;
        end else begin
            none_exp = 1'b0;
            if (idle && bus.vec_valid) begin
                for (int i = 0; i < OUT; i++)
                    if (bus.vec[i]) exp_q.push_back(i);
                none_exp = (exp_q.size() == 0);
            end else if (!idle && bus.idx_ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("m_vec_ready", int'(bus.vec_ready), int'(exp_q.size() == 0));
            check("m_idx_valid", int'(bus.idx_valid), int'(exp_q.size() != 0));
            check("m_none", int'(bus.none), int'(none_exp));
            if (exp_q.size() != 0) begin
                check("m_idx", int'(bus.idx), exp_q[0]);
                check("m_idx_last", int'(bus.idx_last), int'(exp_q.size() == 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [OUT-1:0] v);
        int n = 0;
        while (!bus.vec_ready && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check("send_wait_ready", 0, 1);
        bus.vec       = v;
        bus.vec_valid = 1'b1;
        tick();
        bus.vec_valid = 1'b0;
        // Scribble on vec: the captured vector must not change.
        for (int w = 0; w < OUT / 32; w++) bus.vec[w*32 +: 32] = $urandom;
        $display("vector accepted: %0d bits set, t=%0t", $countones(v), $time);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OUT-1:0] v;
        int seq[4];
        int n;
        int last_seen;
        int last_idx;

        // Reset with a valid vector present: nothing may be accepted.
        bus.vec       = '0;
        bus.vec[3]    = 1'b1;
        bus.vec_valid = 1'b1;
        bus.idx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.vec_valid = 1'b0;
        check("rst_vec_ready", int'(bus.vec_ready), 1);
        check("rst_idx_valid", int'(bus.idx_valid), 0);
        check("rst_idx_last", int'(bus.idx_last), 0);
        check("rst_idx", int'(bus.idx), 0);
        check("rst_none", int'(bus.none), 0);
        tick();
        check("no_accept_in_rst", int'(bus.idx_valid), 0);

        // Single bit 517.
        v = '0; v[517] = 1'b1;
        send(v);
        check("single_idx", int'(bus.idx), 517);
        check("single_valid", int'(bus.idx_valid), 1);
        check("single_last", int'(bus.idx_last), 1);
        tick();
        check("single_ready_after", int'(bus.vec_ready), 1);
        check("single_valid_after", int'(bus.idx_valid), 0);

        // Extremes {0, 31, 32, 1023}.
        v = '0; v[1023] = 1'b1; v[0] = 1'b1; v[31] = 1'b1; v[32] = 1'b1;
        seq = '{0, 31, 32, 1023};
        send(v);
        for (int k = 0; k < 4; k++) begin
            check("ext_idx", int'(bus.idx), seq[k]);
            check("ext_last", int'(bus.idx_last), int'(k == 3));
            tick();
        end
        check("ext_ready_after", int'(bus.vec_ready), 1);

        // Zero vector, then accept another vector during the none pulse.
        send('0);
        check("zero_none", int'(bus.none), 1);
        check("zero_valid", int'(bus.idx_valid), 0);
        check("zero_ready", int'(bus.vec_ready), 1);
        v = '0; v[7] = 1'b1;
        send(v);
        check("zero_none_drop", int'(bus.none), 0);
        check("b2b_idx", int'(bus.idx), 7);
        check("b2b_last", int'(bus.idx_last), 1);
        tick();

        // Backpressure on {5, 700}.
        bus.idx_ready = 1'b0;
        v = '0; v[5] = 1'b1; v[700] = 1'b1;
        send(v);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_idx", int'(bus.idx), 5);
            check("bp_hold_last", int'(bus.idx_last), 0);
            check("bp_vec_ready", int'(bus.vec_ready), 0);
            tick();
        end
        bus.idx_ready = 1'b1;
        check("bp_idx0", int'(bus.idx), 5);
        tick();
        check("bp_idx1", int'(bus.idx), 700);
        check("bp_last1", int'(bus.idx_last), 1);
        check("bp_vec_ready_scan", int'(bus.vec_ready), 0);
        tick();
        check("bp_ready_after", int'(bus.vec_ready), 1);

        // All ones: accept cycle plus 1024 scan cycles.
        v = '1;
        send(v);
        n = 0; last_seen = 0; last_idx = -1;
        while (!bus.vec_ready && n < 3000) begin
            if (bus.idx_last) begin
                last_seen++;
                last_idx = int'(bus.idx);
            end
            n++;
            tick();
        end
        check("ones_cycles", 1 + n, 1025);
        check("ones_last_count", last_seen, 1);
        check("ones_last_idx", last_idx, 1023);

        // Reset after 2 of 4 indices.
        v = '0; v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1; v[4] = 1'b1;
        send(v);
        tick();
        tick();
        check("mid_idx_before_rst", int'(bus.idx), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", int'(bus.idx_valid), 0);
        check("mid_ready", int'(bus.vec_ready), 1);
        check("mid_last", int'(bus.idx_last), 0);
        check("mid_idx", int'(bus.idx), 0);
        v = '0; v[9] = 1'b1;
        send(v);
        check("mid_new_idx", int'(bus.idx), 9);
        check("mid_new_last", int'(bus.idx_last), 1);
        tick();
        check("mid_new_ready", int'(bus.vec_ready), 1);

        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_seq.md
# onehot_encoder_seq

Sequential inverse of the 10-to-1024 one-hot decoder: accepts a 1024-bit vector and returns the 10-bit index of every set bit, lowest index first, one index per cycle. Used wherever decoded select/grant vectors must be converted back to binary indices, including multi-hot vectors. Input and output are valid/ready streams, so the block sits between a vector producer and an index consumer.

## Interface
- `IN`, 10: index width; `OUT` must equal 2**`IN`
- `OUT`, 1024: vector width
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `vec` input `OUT`: vector to encode, sampled on accept
- `vec_valid` input 1: `vec` is valid
- `vec_ready` output 1: block can accept a vector
- `idx` output `IN`: index of the current lowest remaining set bit
- `idx_valid` output 1: `idx` is valid
- `idx_ready` input 1: consumer takes `idx`
- `idx_last` output 1: `idx` is the final set bit of this vector
- `none` output 1: one-cycle pulse; the accepted vector was all zero

## Operation
- States: IDLE and SCAN.
- IDLE:
  - `vec_ready`=1.
  - On `vec_valid`&&`vec_ready`, register `vec` into `rem`.
  - Nonzero `vec` -> SCAN.
  - Zero `vec` -> pulse `none` for the next cycle and stay in IDLE.
- SCAN:
  - `vec_ready`=0.
  - `idx_valid`=1.
  - `idx` = lowest set bit of `rem`.
  - `idx_last`=1 iff `rem` has exactly one bit set.
- Index handshake (`idx_valid`&&`idx_ready`):
  - Clear bit `idx` in `rem`.
  - If `idx_last`, go to IDLE; otherwise stay in SCAN.
- No handshake: `rem`, `idx` and `idx_last` hold.
- `idx`, `idx_valid` and `idx_last` are decoded from registered `rem` and state only. There is no combinational path from `vec`/`vec_valid` to outputs. `idx_ready` may combinationally affect nothing except next-state.
- The vector is captured whole. Changes on `vec` after accept are ignored.
- Reset:
  - `rem`=0, state IDLE.
  - `vec_ready`=1 after reset. During the reset cycle the block must not accept.
  - `idx_valid`=0, `idx_last`=0, `idx`=0, `none`=0.
  - Reset mid-SCAN discards remaining indices without emitting `idx_last`.

## Timing
- Accept-to-first-index latency: first `idx_valid` is 1 cycle after the accepting edge.
- Throughput: 1 index/cycle with `idx_ready` held high.
  - k set bits drain in k cycles.
  - IDLE is re-entered on the edge consuming `idx_last`, so `vec_ready` is 1 the following cycle.
  - Per-vector cost is k+1 cycles; a zero vector costs 1 cycle.
- `none` asserts the cycle after accepting a zero vector, for exactly one cycle. The block may accept another vector in that same cycle.
- Stability: while `idx_valid`&&!`idx_ready`, `idx` and `idx_last` are stable.
- Boundaries:
  - Bit 0 and bit 1023 encode as 0 and 1023.
  - An all-ones vector yields 0..1023 in order, with `idx_last` only on 1023.
  - There is no wrap-around.

## Structure
- Shared package holds:
  - state enum {IDLE, SCAN};
  - `IN`/`OUT` defaults;
  - group width constant G=32 and group count `OUT`/G.
- Priority encoding is a two-level tree built from one sub-module, `prio_enc32`:
  - 32-bit input, lowest-first 5-bit index plus `any` flag.
  - 32 instances, one per 32-bit group of `rem`.
  - One instance over the 32 group `any` flags selects the group.
  - `idx` = {group index, in-group index}.
- Single-bit detection for `idx_last`: `rem` with its lowest set bit cleared equals zero. Use the `rem & (rem-1)` equivalent, computed per group plus the group-any count.

## Test plan
- Single bit: `vec` with only bit 517 set -> one cycle later `idx`=517, `idx_valid`=1, `idx_last`=1; `vec_ready`=1 the cycle after the handshake.
- Extremes: bits {1023, 0, 31, 32} set, `idx_ready`=1 -> `idx` sequence 0, 31, 32, 1023 on consecutive cycles, `idx_last` only with 1023.
- Zero vector: accept all-zero `vec` -> `none`=1 for exactly one cycle; `idx_valid` never rises.
- Backpressure: bits {5, 700} set, `idx_ready`=0 for 3 cycles -> `idx`=5 held stable all 3 cycles; then 5, 700 emitted; `vec_ready` stays 0 throughout SCAN.
- All ones: `vec`=all 1s -> 1024 consecutive indices 0..1023; `idx_last` on 1023 only; `vec_ready` returns 1025 cycles after accept.
- Reset mid-scan: assert `rst` after 2 of 4 indices emitted -> next cycle `idx_valid`=0, `vec_ready`=1, `rem`=0; a new vector with bit 9 set then yields `idx`=9 with `idx_last`=1.
